// File: rtl/fxp_mult_pipe_if.sv
// Handshake and operand/result bundle between the operand fetch path and the
// fixed-point multiplier, plus its result path toward the accumulator.
interface fxp_mult_pipe_if #(
    parameter int W     = 16,
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] ip1;
    logic [LANES*W-1:0] ip2;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] op;
    logic [LANES-1:0]   ovf;

    modport master (
        output in_valid, ip1, ip2, mode, out_ready,
        input  in_ready, out_valid, op, ovf
    );

    modport slave (
        input  in_valid, ip1, ip2, mode, out_ready,
        output in_ready, out_valid, op, ovf
    );
endinterface

// File: rtl/fxp_mult_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier with per-bundle
// round/saturate mode, overflow flags and a bubble-collapsing valid/ready pipe.
module fxp_mult_pipe #(
    parameter int W      = 16,
    parameter int FRAC   = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    fxp_mult_pipe_if.slave bus
);
    localparam int PW = 2*W + 1;

    // Returns {ovf, result}. The extra top bit keeps the rounding carry.
    function automatic logic [W:0] lane_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [1:0]   m);
        logic signed [2*W-1:0] p;
        logic signed [PW-1:0]  pr;
        logic signed [PW-1:0]  r;
        logic                  in_range;
        p        = (2*W)'($signed(a)) * (2*W)'($signed(b));
        pr       = {p[2*W-1], p};
        pr       = pr + (m[0] ? (PW'(1) << (FRAC-1)) : PW'(0));
        r        = pr >>> FRAC;
        in_range = (&r[PW-1:W-1]) || !(|r[PW-1:W-1]);
        if (!in_range && m[1])
            lane_mul = {1'b1, r[PW-1], {(W-1){!r[PW-1]}}};
        else
            lane_mul = {!in_range, r[W-1:0]};
    endfunction

    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   res_ovf;

    // The whole product is formed on entry, so later stages only carry the
    // finished bundle and a mode change can never reach an in-flight bundle.
    always_comb begin
        logic [W:0] lr;
        res     = '0;
        res_ovf = '0;
        lr      = '0;
        for (int i = 0; i < LANES; i++) begin
            lr               = lane_mul(bus.ip1[i*W +: W], bus.ip2[i*W +: W], bus.mode);
            res[i*W +: W]    = lr[W-1:0];
            res_ovf[i]       = lr[W];
        end
    end

    logic [STAGES-1:0]  vld;
    logic [STAGES-1:0]  ld;
    logic [STAGES-1:0]  src_v;
    logic [LANES*W-1:0] dat   [STAGES];
    logic [LANES*W-1:0] src_d [STAGES];
    logic [LANES-1:0]   ovf_q [STAGES];
    logic [LANES-1:0]   src_f [STAGES];

    // Stage k can load unless it and every stage after it are full while the
    // consumer is stalled; written flat to avoid a ripple through ld itself.
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++)
            ld[k] = bus.out_ready ||
                    ((vld | ((STAGES'(1) << k) - STAGES'(1))) != '1);
    end

    always_comb begin
        src_v    = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_d[k] = '0;
            src_f[k] = '0;
        end
        src_v[0] = bus.in_valid;
        src_d[0] = res;
        src_f[0] = res_ovf;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld[k-1];
            src_d[k] = dat[k-1];
            src_f[k] = ovf_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat[k]   <= '0;
                ovf_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= src_v[k];
                    if (src_v[k]) begin
                        dat[k]   <= src_d[k];
                        ovf_q[k] <= src_f[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.op        = dat[STAGES-1];
    assign bus.ovf       = ovf_q[STAGES-1];
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe: hand-computed arithmetic vectors, latency,
// backpressure, bubbles, throughput and mid-flight reset.
module tb_fxp_mult_pipe;
    localparam int W      = 16;
    localparam int FRAC   = 8;
    localparam int LANES  = 4;
    localparam int STAGES = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [67:0] exp_q [$];

    fxp_mult_pipe_if #(.W(W), .LANES(LANES)) bus ();

    fxp_mult_pipe #(.W(W), .FRAC(FRAC), .LANES(LANES), .STAGES(STAGES)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference written in plain integer arithmetic; returns {ovf, op}.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] m);
        logic [63:0] o;
        logic [3:0]  f;
        longint      p;
        longint      r;
        o = '0;
        f = '0;
        for (int j = 0; j < LANES; j++) begin
            p = longint'($signed(a[j*16 +: 16])) * longint'($signed(b[j*16 +: 16]));
            if (m[0]) p = p + 128;
            r = p >>> 8;
            if (r > 32767) begin
                f[j] = 1'b1;
                o[j*16 +: 16] = m[1] ? 16'h7FFF : r[15:0];
            end else if (r < -32768) begin
                f[j] = 1'b1;
                o[j*16 +: 16] = m[1] ? 16'h8000 : r[15:0];
            end else begin
                o[j*16 +: 16] = r[15:0];
            end
        end
        return {f, o};
    endfunction

    function automatic logic [63:0] gen_a(input int k);
        logic [15:0] t;
        t = k[15:0];
        return {16'h7F00 - t*16'h0123, t*16'h0131 + 16'h0040,
                16'h0000 - t*16'h0077, t*16'h0900};
    endfunction

    function automatic logic [63:0] gen_b(input int k);
        logic [15:0] t;
        t = k[15:0];
        return {16'h0200 + t*16'h0011, 16'hFF00 + t*16'h0021,
                16'h0180 - t*16'h0007, 16'h0100 + t*16'h0050};
    endfunction

    // One cycle: drive at the falling edge, then score the transfers that the
    // next rising edge will perform.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] m, input logic ordy, output logic acc);
        logic [67:0] e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.ip1       = a;
        bus.ip2       = b;
        bus.mode      = m;
        bus.out_ready = ordy;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_op", bus.op, e[63:0]);
                chk("stream_ovf", {60'd0, bus.ovf}, {60'd0, e[67:64]});
            end
        end
        if (acc) exp_q.push_back(model(a, b, m));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++)
            step(1'b0, '0, '0, 2'b00, 1'b1, acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic dir(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] m, input logic [63:0] eo, input logic [3:0] ef);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.ip1       = a;
        bus.ip2       = b;
        bus.mode      = m;
        bus.out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mode     = ~m;
        bus.ip1      = '1;
        n = 1;
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({tag, "_lat"}, 64'(n), 64'(STAGES));
        chk({tag, "_op"}, bus.op, eo);
        chk({tag, "_ovf"}, {60'd0, bus.ovf}, {60'd0, ef});
    endtask

    initial begin
        logic        acc;
        logic        have_ref;
        logic [63:0] ref_op;
        int          n_acc;
        int          id;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ip1       = '0;
        bus.ip2       = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_op", bus.op, 64'd0);
        chk("rst_ovf", {60'd0, bus.ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        dir("basic", {16'hFFFF, 16'h0001, 16'hFF00, 16'h0180},
                     {16'h0080, 16'h0080, 16'h0180, 16'h0200}, 2'b00,
                     {16'hFFFF, 16'h0000, 16'hFE80, 16'h0300}, 4'b0000);
        dir("round", {16'hFFFF, 16'h0001, 16'hFF00, 16'h0180},
                     {16'h0080, 16'h0080, 16'h0180, 16'h0200}, 2'b01,
                     {16'h0000, 16'h0001, 16'hFE80, 16'h0300}, 4'b0000);
        dir("sat",   {16'hFFFF, 16'h0180, 16'h8000, 16'h7F00},
                     {16'h0080, 16'h0200, 16'h0200, 16'h0200}, 2'b10,
                     {16'hFFFF, 16'h0300, 16'h8000, 16'h7FFF}, 4'b0011);
        dir("wrap",  {16'hFFFF, 16'h0180, 16'h8000, 16'h7F00},
                     {16'h0080, 16'h0200, 16'h0200, 16'h0200}, 2'b00,
                     {16'hFFFF, 16'h0300, 16'h0000, 16'hFE00}, 4'b0011);
        dir("rndsat", {16'hFFFF, 16'h0180, 16'h8000, 16'h7F00},
                      {16'h0080, 16'h0200, 16'h0200, 16'h0200}, 2'b11,
                      {16'h0000, 16'h0300, 16'h8000, 16'h7FFF}, 4'b0011);
        dir("edge",  {16'h0100, 16'h8000, 16'h7FFF, 16'h8000},
                     {16'h0100, 16'hFF00, 16'h0100, 16'h0100}, 2'b10,
                     {16'h0100, 16'h7FFF, 16'h7FFF, 16'h8000}, 4'b0100);
        @(negedge clk);

        // Fill from empty against a stalled consumer.
        id = 0;
        n_acc = 0;
        have_ref = 1'b0;
        ref_op = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, gen_a(id), gen_b(id), id[1:0], 1'b0, acc);
            if (acc) begin
                n_acc++;
                id++;
            end
            if (bus.out_valid) begin
                if (have_ref) chk("stall_hold", bus.op, ref_op);
                else begin
                    ref_op   = bus.op;
                    have_ref = 1'b1;
                end
            end
        end
        chk("stall_accepts", 64'(n_acc), 64'(STAGES));
        chk("stall_rdy_low", {63'd0, bus.in_ready}, 64'd0);
        drain();

        // Ten bundles with the consumer stalled in cycles 4-9.
        n_acc = 0;
        for (int i = 0; i < 60 && (n_acc < 10 || exp_q.size() > 0); i++) begin
            step(n_acc < 10, gen_a(id), gen_b(id), id[1:0], !(i >= 4 && i <= 9), acc);
            if (acc) begin
                n_acc++;
                id++;
            end
        end
        chk("bp_sent", 64'(n_acc), 64'd10);
        chk("bp_empty", 64'(exp_q.size()), 64'd0);

        // Bubbles with a randomly stalling consumer.
        for (int i = 0; i < 40; i++) begin
            step(i[0] == 1'b0, gen_a(id), gen_b(id), id[1:0], 1'($urandom_range(0, 1)), acc);
            if (acc) id++;
        end
        drain();

        // Full rate whenever the consumer is ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, gen_a(id), gen_b(id), id[1:0], 1'b1, acc);
            chk("thru_acc", {63'd0, acc}, 64'd1);
            id++;
        end
        drain();

        // Reset with three bundles in flight.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, gen_a(id), gen_b(id), 2'b01, 1'b0, acc);
            id++;
        end
        chk("flight_cnt", 64'(exp_q.size()), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mrst_op", bus.op, 64'd0);
        chk("mrst_ovf", {60'd0, bus.ovf}, 64'd0);
        chk("mrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 10; i++)
            step(1'b0, '0, '0, 2'b00, 1'b1, acc);
        chk("mrst_quiet", {63'd0, bus.out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
